// File: rtl/jpeg_line_fifo_pkg.sv
// jpeg_line_fifo_pkg: shared constants and helpers for the JPEG line FIFO.
// Default geometry, clog2 and the packed word layout (eol tag above data).
package jpeg_line_fifo_pkg;

    localparam int CH_NUM_DEF       = 3;
    localparam int CH_WIDTH_DEF     = 8;
    localparam int DEPTH_WIDTH_DEF  = 12;
    localparam int STRIP_LINES_DEF  = 8;
    localparam int ALMOST_FULL_DEF  = 1020;
    localparam int ALMOST_EMPTY_DEF = 6;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // The eol tag sits directly above the pixel data bits.
    function automatic int tag_bit(input int ch_num, input int ch_width);
        return ch_num * ch_width;
    endfunction

endpackage

// File: rtl/jpeg_line_fifo_ram.sv
// jpeg_line_fifo_ram: simple dual-port RAM, synchronous read.
// No reset on the array so it maps onto block RAM.
module jpeg_line_fifo_ram
    import jpeg_line_fifo_pkg::*;
#(
    parameter int W  = 25,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [1 << AW];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port, holds when not enabled
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/jpeg_line_fifo_mc.sv
// jpeg_line_fifo_mc: multi-channel line FIFO with eol tags and line count.
// Define JPEG_LINE_FIFO_OREG_EN to add an output register (2-cycle read).
module jpeg_line_fifo_mc
    import jpeg_line_fifo_pkg::*;
#(
    parameter int CH_NUM           = CH_NUM_DEF,
    parameter int CH_WIDTH         = CH_WIDTH_DEF,
    parameter int DEPTH_WIDTH      = DEPTH_WIDTH_DEF,
    parameter int ALMOST_FULL_NUM  = ALMOST_FULL_DEF,
    parameter int ALMOST_EMPTY_NUM = ALMOST_EMPTY_DEF,
    parameter int STRIP_LINES      = STRIP_LINES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [CH_NUM*CH_WIDTH-1:0]   wr_data,
    input  logic                         wr_eol,
    output logic                         wr_full,
    output logic                         almost_full,
    output logic                         wr_overflow,
    input  logic                         rd_en,
    output logic [CH_NUM*CH_WIDTH-1:0]   rd_data,
    output logic                         rd_eol,
    output logic                         rd_valid,
    output logic                         rd_empty,
    output logic                         almost_empty,
    output logic                         rd_underflow,
    output logic [DEPTH_WIDTH:0]         water_level,
    output logic [DEPTH_WIDTH:0]         line_cnt,
    output logic                         strip_ready
);

    localparam int DW    = tag_bit(CH_NUM, CH_WIDTH);
    localparam int AW    = DEPTH_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int PW    = clog2(DEPTH) + 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t DEPTH_L = ptr_t'(DEPTH);
    localparam ptr_t AF_L    = ptr_t'(ALMOST_FULL_NUM);
    localparam ptr_t AE_L    = ptr_t'(ALMOST_EMPTY_NUM);
    localparam ptr_t SL_L    = ptr_t'(STRIP_LINES);

    if (ALMOST_FULL_NUM > DEPTH || STRIP_LINES < 1) begin : g_bad_cfg
        $error("jpeg_line_fifo_mc: bad ALMOST_FULL_NUM or STRIP_LINES");
    end

    ptr_t wr_ptr, rd_ptr, line_q;
    ptr_t wr_ptr_n, rd_ptr_n, lvl_n, line_n;
    logic wr_acc, rd_acc, rd_tag;
    logic [DEPTH-1:0] eol_sh;
    logic [DW:0]   ram_q;
    logic          rv1, dvld;
    logic [DW-1:0] d1;
    logic          e1;

    assign wr_acc = !clr && wr_en && !wr_full;
    assign rd_acc = !clr && rd_en && !rd_empty;
    assign rd_tag = eol_sh[rd_ptr[AW-1:0]];

    // Next-state pointers, level and line count
    always_comb begin
        wr_ptr_n = wr_ptr + ptr_t'(wr_acc);
        rd_ptr_n = rd_ptr + ptr_t'(rd_acc);
        lvl_n    = wr_ptr_n - rd_ptr_n;
        line_n   = line_q + ptr_t'(wr_acc && wr_eol)
                 - ptr_t'(rd_acc && rd_tag);
    end

    // Tag shadow so line_cnt drops in the same cycle as the read
    always_ff @(posedge clk) begin
        if (wr_acc) eol_sh[wr_ptr[AW-1:0]] <= wr_eol;
    end

    // Pointers, line count, registered flags and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            line_q       <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            strip_ready  <= 1'b0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            line_q       <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            strip_ready  <= 1'b0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            line_q       <= line_n;
            wr_full      <= (lvl_n == DEPTH_L);
            almost_full  <= (lvl_n >= AF_L);
            rd_empty     <= (lvl_n == '0);
            almost_empty <= (lvl_n <= AE_L);
            strip_ready  <= (line_n >= SL_L);
            wr_overflow  <= wr_overflow | (wr_en & wr_full);
            rd_underflow <= rd_underflow | (rd_en & rd_empty);
        end
    end

    assign water_level = wr_ptr - rd_ptr;
    assign line_cnt    = line_q;

    jpeg_line_fifo_ram #(
        .W  (DW + 1),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({wr_eol, wr_data}),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    // Read-valid pulse and a "RAM output is meaningful" qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1  <= 1'b0;
            dvld <= 1'b0;
        end else if (clr) begin
            rv1  <= 1'b0;
            dvld <= 1'b0;
        end else begin
            rv1 <= rd_acc;
            if (rd_acc) dvld <= 1'b1;
        end
    end

    // The RAM has no reset, so its output reads as zero until a first read
    assign d1 = dvld ? ram_q[DW-1:0] : '0;
    assign e1 = dvld && ram_q[DW];

`ifdef JPEG_LINE_FIFO_OREG_EN
    logic [DW-1:0] d2;
    logic          e2, rv2;

    // Extra output stage, loads only when stage one carries a new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d2  <= '0;
            e2  <= 1'b0;
            rv2 <= 1'b0;
        end else if (clr) begin
            d2  <= '0;
            e2  <= 1'b0;
            rv2 <= 1'b0;
        end else begin
            rv2 <= rv1;
            if (rv1) begin
                d2 <= d1;
                e2 <= e1;
            end
        end
    end

    assign rd_data  = d2;
    assign rd_eol   = e2;
    assign rd_valid = rv2;
`else
    assign rd_data  = d1;
    assign rd_eol   = e1;
    assign rd_valid = rv1;
`endif

endmodule

// File: tb/tb_jpeg_line_fifo_mc.sv
// tb_jpeg_line_fifo_mc: directed and random checks against a queue model.
// Honours JPEG_LINE_FIFO_OREG_EN for the expected read latency.
module tb_jpeg_line_fifo_mc;

    localparam int DW = 24;
    localparam int DEPTH = 16;
    localparam int AFN = 14;
    localparam int AEN = 2;
    localparam int SLN = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_eol = 1'b0;
    logic          rd_en = 1'b0;
    logic          wr_full, almost_full, wr_overflow;
    logic [DW-1:0] rd_data;
    logic          rd_eol, rd_valid, rd_empty, almost_empty, rd_underflow;
    logic [4:0]    water_level, line_cnt;
    logic          strip_ready;

    int tests = 0;
    int fails = 0;

    jpeg_line_fifo_mc #(
        .CH_NUM           (3),
        .CH_WIDTH         (8),
        .DEPTH_WIDTH      (4),
        .ALMOST_FULL_NUM  (AFN),
        .ALMOST_EMPTY_NUM (AEN),
        .STRIP_LINES      (SLN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_eol       (wr_eol),
        .wr_full      (wr_full),
        .almost_full  (almost_full),
        .wr_overflow  (wr_overflow),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_eol       (rd_eol),
        .rd_valid     (rd_valid),
        .rd_empty     (rd_empty),
        .almost_empty (almost_empty),
        .rd_underflow (rd_underflow),
        .water_level  (water_level),
        .line_cnt     (line_cnt),
        .strip_ready  (strip_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: queue of {eol, data} words plus output registers
    logic [DW:0]   mq[$];
    bit            m_ovf, m_unf;
    bit            m_v;
    logic [DW-1:0] m_d;
    bit            m_e;
    bit            s1_v;
    logic [DW:0]   s1_w;

    function automatic int m_lines();
        int n = 0;
        foreach (mq[i]) if (mq[i][DW]) n++;
        return n;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_unf = 0;
        m_v = 0; m_d = '0; m_e = 0;
        s1_v = 0; s1_w = '0;
    endtask

    task automatic model_step(input bit we, input logic [DW-1:0] wd,
                              input bit weol, input bit re, input bit cl);
        bit full, empty, racc, wacc;
        logic [DW:0] w;
        if (cl) begin
            model_reset();
            return;
        end
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (we && full) m_ovf = 1;
        if (re && empty) m_unf = 1;
        racc = re && !empty;
        wacc = we && !full;
        w = '0;
        if (racc) w = mq.pop_front();
        if (wacc) mq.push_back({weol, wd});
`ifdef JPEG_LINE_FIFO_OREG_EN
        m_v = s1_v;
        if (s1_v) {m_e, m_d} = s1_w;
        s1_v = racc;
        if (racc) s1_w = w;
`else
        m_v = racc;
        if (racc) {m_e, m_d} = w;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("water_level", 32'(water_level), n);
        chk("line_cnt", 32'(line_cnt), m_lines());
        chk("strip_ready", 32'(strip_ready), 32'(m_lines() >= SLN));
        chk("wr_full", 32'(wr_full), 32'(n == DEPTH));
        chk("rd_empty", 32'(rd_empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AFN));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEN));
        chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
        chk("rd_underflow", 32'(rd_underflow), 32'(m_unf));
        chk("rd_valid", 32'(rd_valid), 32'(m_v));
        chk("rd_data", 32'(rd_data), 32'(m_d));
        chk("rd_eol", 32'(rd_eol), 32'(m_e));
    endtask

    task automatic cyc(input bit we, input logic [DW-1:0] wd,
                       input bit weol, input bit re, input bit cl);
        wr_en = we; wr_data = wd; wr_eol = weol; rd_en = re; clr = cl;
        model_step(we, wd, weol, re, cl);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0);
    endtask

    initial begin
        int pw, pr;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Fill to full, then one write too many
        for (int i = 1; i <= 16; i++) begin
            cyc(1, DW'(i), 0, 0, 0);
            if (i == 13) chk("af_before", 32'(almost_full), 0);
            if (i == 14) chk("af_rise", 32'(almost_full), 1);
        end
        chk("fill_full", 32'(wr_full), 1);
        chk("fill_level", 32'(water_level), 16);
        cyc(1, 24'h000011, 0, 0, 0);
        chk("fill_ovf", 32'(wr_overflow), 1);
        chk("fill_level17", 32'(water_level), 16);

        // Drain everything, then one read too many
        for (int i = 1; i <= 16; i++) cyc(0, '0, 0, 1, 0);
        idle();
        idle();
        chk("drain_empty", 32'(rd_empty), 1);
        chk("drain_last", 32'(rd_data), 32'h10);
        cyc(0, '0, 0, 1, 0);
        chk("drain_unf", 32'(rd_underflow), 1);
        cyc(0, '0, 0, 0, 1);

        // Three lines of five words
        for (int i = 0; i < 15; i++) cyc(1, DW'(32'h100 + i), (i % 5) == 4, 0, 0);
        chk("lines_cnt", 32'(line_cnt), 3);
        chk("lines_strip", 32'(strip_ready), 1);
        for (int i = 0; i < 5; i++) cyc(0, '0, 0, 1, 0);
        idle();
        idle();
        chk("lines_eol5", 32'(rd_eol), 1);
        chk("lines_after", 32'(line_cnt), 2);

        // Simultaneous read and write at full
        for (int i = 0; i < 6; i++) cyc(1, DW'(32'h200 + i), 0, 0, 0);
        chk("sim_full", 32'(wr_full), 1);
        cyc(1, 24'hABCDEF, 0, 1, 0);
        chk("sim_level", 32'(water_level), 15);
        chk("sim_ovf", 32'(wr_overflow), 1);

        // Pointer wrap with steady level 8
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++)
            cyc(1, DW'($urandom), $urandom_range(0, 3) == 0, 1, 0);
        chk("wrap_level", 32'(water_level), 8);

        // clr mid-operation beats a concurrent write
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 1, 0);
        for (int i = 0; i < 9; i++) cyc(1, DW'($urandom), i == 2, 0, 0);
        chk("clr_pre_level", 32'(water_level), 9);
        chk("clr_pre_lines", 32'(line_cnt), 1);
        cyc(1, 24'h123456, 1, 0, 1);
        chk("clr_level", 32'(water_level), 0);
        chk("clr_lines", 32'(line_cnt), 0);
        chk("clr_unf", 32'(rd_underflow), 0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) cyc(1, DW'($urandom), i == 1, 0, 0);
        wr_en = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_level", 32'(water_level), 0);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        #2 rst_n = 1'b1;

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 500; i++) begin
            pw = ((i / 60) % 2 == 0) ? 75 : 30;
            pr = 100 - pw;
            cyc($urandom_range(0, 99) < pw, DW'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 99) < pr,
                $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jpeg_line_fifo_mc.md
Name: jpeg_line_fifo_mc

Overview:
- Single-clock, parametrised line FIFO for the JPEG encoder front end.
- Successor to the fixed 24-bit line FIFO: channel count, channel width and depth are generalised.
- Adds per-word end-of-line tagging, a complete-line counter, a strip-ready flag for MCU row assembly, synchronous flush, and sticky overflow/underflow flags.
- Sits between the pixel capture path and the colour-convert/DCT block strip reader.

Parameters:
- CH_NUM, 3, number of colour channels packed per word.
- CH_WIDTH, 8, bits per channel; data width DW = CH_NUM*CH_WIDTH.
- DEPTH_WIDTH, 12, log2 of FIFO depth; DEPTH = 2^DEPTH_WIDTH words.
- ALMOST_FULL_NUM, 1020, almost_full threshold in words.
- ALMOST_EMPTY_NUM, 6, almost_empty threshold in words.
- STRIP_LINES, 8, complete lines required for strip_ready (8 or 16 for MCU rows).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush.
- wr_en  in  1  write request.
- wr_data  in  DW  pixel word; channel 0 in the LSBs.
- wr_eol  in  1  last pixel of a line; sampled with wr_en.
- wr_full  out  1  FIFO full.
- almost_full  out  1  water_level >= ALMOST_FULL_NUM.
- wr_overflow  out  1  sticky: write attempted while full.
- rd_en  in  1  read request.
- rd_data  out  DW  read word.
- rd_eol  out  1  eol tag of rd_data.
- rd_valid  out  1  rd_data/rd_eol valid this cycle.
- rd_empty  out  1  FIFO empty.
- almost_empty  out  1  water_level <= ALMOST_EMPTY_NUM.
- rd_underflow  out  1  sticky: read attempted while empty.
- water_level  out  DEPTH_WIDTH+1  words stored.
- line_cnt  out  DEPTH_WIDTH+1  complete lines stored (count of stored eol tags).
- strip_ready  out  1  line_cnt >= STRIP_LINES.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, water_level, line_cnt, rd_data, rd_eol, rd_valid, wr_overflow, rd_underflow = 0.
  - rd_empty = 1, almost_empty = 1, wr_full = 0, almost_full = 0, strip_ready = 0.
- Storage and pointers:
  - Storage is DEPTH words of DW+1 bits; the extra bit holds the eol tag.
  - wr_ptr and rd_ptr are DEPTH_WIDTH+1 bits; the address is the low DEPTH_WIDTH bits.
  - Pointers wrap naturally; water_level = wr_ptr - rd_ptr, modulo 2^(DEPTH_WIDTH+1).
- Accept rules:
  - Write accepted when wr_en && !wr_full.
  - Read accepted when rd_en && !rd_empty.
  - At full, a simultaneous read and write: the write is blocked and the read proceeds, so water_level drops by 1.
  - At empty, a simultaneous read and write: the read is ignored and the write proceeds.
  - Otherwise a simultaneous read and write leaves water_level unchanged.
- Flags:
  - All flags are registered and computed from the next-state level, so they are exact in the same cycle that water_level updates.
  - wr_full = (level == DEPTH); rd_empty = (level == 0).
- Read latency:
  - rd_data, rd_eol and rd_valid are registered; rd_valid is high 1 cycle after an accepted read.
  - rd_data holds its last value when no read is accepted; rd_valid pulses only on accepted reads.
- line_cnt:
  - Increments on an accepted write with wr_eol=1.
  - Decrements on an accepted read whose stored tag = 1.
  - Both in the same cycle: unchanged.
  - Cannot overflow, because every line occupies at least one word.
- Error flags:
  - wr_overflow sets on wr_en && wr_full; rd_underflow sets on rd_en && rd_empty.
  - Both stay set until clr or reset.
- clr:
  - Takes priority over wr_en and rd_en in the same cycle.
  - Next cycle, all state equals the reset values; RAM contents are not cleared.
- Thresholds: ALMOST_FULL_NUM must be <= DEPTH and STRIP_LINES must be >= 1; both checked by an elaboration-time assertion.

Optional Feature:
- Macro: JPEG_LINE_FIFO_OREG_EN.
- Defined:
  - Adds an output register stage after the RAM; read latency becomes 2 cycles.
  - rd_valid is delayed to match; rd_data/rd_eol of the extra stage reset to 0 and are cleared by clr.
  - Eases timing at high clk.
- Undefined: read latency is 1 cycle as specified above.

Decomposition:
- Package jpeg_line_fifo_pkg holds:
  - default parameter constants (CH_NUM, CH_WIDTH, DEPTH_WIDTH, STRIP_LINES);
  - a clog2 function;
  - the word-layout constants: tag bit index = DW.
- Sub-module jpeg_line_fifo_ram: simple dual-port RAM, width DW+1, depth DEPTH, synchronous read, no reset on the array, so it maps to block RAM.
- All control stays in jpeg_line_fifo_mc.

Test Plan:
All scenarios use DEPTH_WIDTH=4 (16 words), ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2, STRIP_LINES=2, CH_NUM=3, CH_WIDTH=8.
- Fill: write 16 words 0x000001..0x000010 with no reads -> almost_full rises after the 14th write; wr_full=1 and water_level=16 after the 16th; a 17th write sets wr_overflow=1 and leaves water_level=16.
- Drain: read all 16 words -> rd_data = 0x000001..0x000010 in order, each with rd_valid 1 cycle after rd_en; rd_empty=1 at the end; one extra read sets rd_underflow=1.
- Lines: write 3 lines of 5 words with wr_eol on each 5th word -> line_cnt goes 1, 2, 3 and strip_ready=1 once line_cnt=2; reading 5 words returns rd_eol=1 on the 5th and line_cnt=2.
- Simultaneous at full: at level=16, assert wr_en and rd_en together -> read accepted, write rejected, water_level=15, wr_overflow set.
- Wrap: 40 interleaved write/read cycles at level 8 -> data ordering intact across pointer wrap, water_level stays 8.
- clr and reset mid-operation: at level=9 with line_cnt=1, assert clr together with wr_en -> next cycle level=0, line_cnt=0, rd_empty=1, sticky flags cleared; rst_n low mid-burst gives the same result asynchronously.
